// File: rtl/apb_slave_mem.sv
// APB3 completer with a local register-file memory.
// Programmable wait states, PSLVERR on out-of-range, sticky protocol flag.
module apb_slave_mem #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int DEPTH       = 200,
    parameter int WAIT_STATES = 2
) (
    input  logic          i_pclk,
    input  logic          i_preset,
    input  logic          i_psel,
    input  logic          i_penable,
    input  logic          i_pwrite,
    input  logic [AW-1:0] i_paddr,
    input  logic [DW-1:0] i_pwdata,
    output logic [DW-1:0] o_prdata,
    output logic          o_pready,
    output logic          o_pslverr,
    output logic          o_proto_err
);

    localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // The register only ever holds IDLE or ACCESS. SETUP is the bus
    // cycle itself, decoded from the inputs, so the capture lands on
    // its exiting edge and a zero-wait pready can appear in ACCESS 1.
    state_t          r_state;
    state_t          w_state_nxt;
    state_t          w_phase;

    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    logic [AW-1:0]   r_addr;
    logic            r_write;
    logic [DW-1:0]   r_wdata;
    logic            r_oor;

    logic            r_pready;
    logic            r_pslverr;
    logic [DW-1:0]   r_prdata;
    logic            r_proto_err;

    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_capture;
    logic            w_rdy_nxt;
    logic            w_complete;
    logic            w_viol;
    logic            w_in_oor;
    logic [AW-1:0]   w_sel_addr;
    logic            w_sel_write;
    logic            w_sel_oor;
    logic [DW-1:0]   w_rd_word;
    logic            w_commit;

    function automatic logic is_oor(input logic [AW-1:0] a);
        return (32'(a) >= 32'(DEPTH));
    endfunction

    // Phase decode, next state, counter and handshake decisions.
    always_comb begin
        w_phase     = S_IDLE;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_rdy_nxt   = 1'b0;
        w_complete  = 1'b0;
        w_viol      = 1'b0;

        if (r_state == S_ACCESS) begin
            w_phase = S_ACCESS;
        end else if (i_psel && !i_penable) begin
            w_phase = S_SETUP;
        end else begin
            w_phase = S_IDLE;
        end

        unique case (w_phase)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
                if (i_psel && i_penable) begin
                    w_viol = 1'b1;
                end
            end
            S_SETUP: begin
                w_capture   = 1'b1;
                w_cnt_nxt   = CNT_LOAD;
                w_state_nxt = S_ACCESS;
                if (ZERO_WAIT) begin
                    w_rdy_nxt = 1'b1;
                end
            end
            S_ACCESS: begin
                if (!i_psel || !i_penable) begin
                    w_viol      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_pready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ACCESS;
                    if (r_cnt <= CNT_ONE) begin
                        w_rdy_nxt = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Response operands: live bus values on the capture edge, else the
    // values latched during SETUP.
    always_comb begin
        w_in_oor    = is_oor(i_paddr);
        w_sel_addr  = w_capture ? i_paddr  : r_addr;
        w_sel_write = w_capture ? i_pwrite : r_write;
        w_sel_oor   = w_capture ? w_in_oor : r_oor;
        w_commit    = w_complete && r_write && !r_oor;
        w_rd_word   = '0;
        if (!w_sel_oor) begin
            w_rd_word = r_mem[w_sel_addr];
        end
    end

    // State register.
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait-state counter.
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Latch the request on the SETUP exit edge; later bus changes are ignored.
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_oor   <= 1'b0;
        end else if (w_capture) begin
            r_addr  <= i_paddr;
            r_write <= i_pwrite;
            r_wdata <= i_pwdata;
            r_oor   <= w_in_oor;
        end
    end

    // Registered pready/pslverr for one cycle; read data loaded alongside.
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_pready  <= w_rdy_nxt;
            r_pslverr <= w_rdy_nxt && w_sel_oor;
            if (w_rdy_nxt && !w_sel_write) begin
                r_prdata <= w_rd_word;
            end
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_proto_err <= 1'b0;
        end else if (w_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    // Memory: cleared by reset, written only on an in-range completion.
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign o_pready    = r_pready  && i_psel;
    assign o_pslverr   = r_pslverr && i_psel;
    assign o_prdata    = r_prdata;
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: one 2-wait and one zero-wait instance,
// checked each cycle against a transaction-level model.
module tb_apb_slave_mem;

    localparam int DEPTH = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] psel;
    logic [1:0] penable;
    logic [1:0] pwrite;
    logic [7:0] paddr  [2];
    logic [7:0] pwdata [2];
    logic [7:0] prdata [2];
    logic [1:0] pready;
    logic [1:0] pslverr;
    logic [1:0] proto;

    always #5 clk = ~clk;

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .i_pclk(clk), .i_preset(rst),
        .i_psel(psel[0]), .i_penable(penable[0]), .i_pwrite(pwrite[0]),
        .i_paddr(paddr[0]), .i_pwdata(pwdata[0]),
        .o_prdata(prdata[0]), .o_pready(pready[0]),
        .o_pslverr(pslverr[0]), .o_proto_err(proto[0])
    );

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .i_pclk(clk), .i_preset(rst),
        .i_psel(psel[1]), .i_penable(penable[1]), .i_pwrite(pwrite[1]),
        .i_paddr(paddr[1]), .i_pwdata(pwdata[1]),
        .o_prdata(prdata[1]), .o_pready(pready[1]),
        .o_pslverr(pslverr[1]), .o_proto_err(proto[1])
    );

    // Model state: memory image, last read data, sticky flag,
    // expected handshake for the current cycle, effects due at next edge.
    logic [7:0] mem_m  [2][256];
    logic [7:0] prd_m  [2];
    logic [1:0] proto_m;
    logic [1:0] exp_rdy;
    logic [1:0] exp_err;
    logic [1:0] pend_w;
    logic [1:0] pend_p;
    logic [7:0] pend_a [2];
    logic [7:0] pend_d [2];

    int nvec = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) mem_m[d][a] = 8'h00;
            prd_m[d]  = 8'h00;
            proto_m[d] = 1'b0;
            exp_rdy[d] = 1'b0;
            exp_err[d] = 1'b0;
            pend_w[d]  = 1'b0;
            pend_p[d]  = 1'b0;
            pend_a[d]  = 8'h00;
            pend_d[d]  = 8'h00;
        end
    endtask

    // Advance one clock; apply model effects of the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pend_w[d]) mem_m[d][pend_a[d]] = pend_d[d];
            if (pend_p[d]) proto_m[d] = 1'b1;
            pend_w[d]  = 1'b0;
            pend_p[d]  = 1'b0;
            exp_rdy[d] = 1'b0;
            exp_err[d] = 1'b0;
        end
    endtask

    task automatic idle(input int d);
        step();
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    // Full transfer; returns during the cycle where pready must be 1.
    // paddr/pwdata are disturbed during ACCESS and must be ignored.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] a_late);
        int ws = ws_of(d);
        step();
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd;
        for (int k = 1; k <= ws + 1; k++) begin
            step();
            penable[d] = 1'b1;
            paddr[d]   = a_late;
            pwdata[d]  = wd ^ 8'hFF;
            if (k == ws + 1) begin
                exp_rdy[d] = 1'b1;
                exp_err[d] = (a >= DEPTH);
                if (!wr) begin
                    prd_m[d] = (a < DEPTH) ? mem_m[d][a] : 8'h00;
                end else if (a < DEPTH) begin
                    pend_w[d] = 1'b1;
                    pend_a[d] = a;
                    pend_d[d] = wd;
                end
            end
        end
    endtask

    task automatic drop_psel(input int d, input logic [7:0] a, input logic [7:0] wd);
        step();
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
        paddr[d] = a; pwdata[d] = wd;
        step();
        psel[d] = 1'b0; penable[d] = 1'b0;
        pend_p[d] = 1'b1;
    endtask

    task automatic drop_penable(input int d, input logic [7:0] a, input logic [7:0] wd);
        step();
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
        paddr[d] = a; pwdata[d] = wd;
        step();
        penable[d] = 1'b1;
        step();
        penable[d] = 1'b0;
        pend_p[d] = 1'b1;
    endtask

    task automatic no_setup(input int d, input logic [7:0] a, input logic [7:0] wd);
        step();
        psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b1;
        paddr[d] = a; pwdata[d] = wd;
        pend_p[d] = 1'b1;
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d pready", d), {7'd0, pready[d]}, {7'd0, exp_rdy[d]});
                chk($sformatf("dut%0d pslverr", d), {7'd0, pslverr[d]}, {7'd0, exp_err[d]});
                chk($sformatf("dut%0d prdata", d), prdata[d], prd_m[d]);
                chk($sformatf("dut%0d proto_err", d), {7'd0, proto[d]}, {7'd0, proto_m[d]});
            end
        end
    end

    initial begin
        rst = 1'b1;
        psel = '0; penable = '0; pwrite = '0;
        for (int d = 0; d < 2; d++) begin
            paddr[d] = 8'h00;
            pwdata[d] = 8'h00;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset pready", {7'd0, pready[d]}, 8'h00);
            chk("reset pslverr", {7'd0, pslverr[d]}, 8'h00);
            chk("reset prdata", prdata[d], 8'h00);
            chk("reset proto_err", {7'd0, proto[d]}, 8'h00);
        end
        step();
        rst = 1'b0;

        // Write then read same address, 2 wait states.
        xfer(0, 1'b1, 8'h10, 8'hA5, 8'h10);
        chk("t2 write pready", {7'd0, pready[0]}, 8'h01);
        xfer(0, 1'b0, 8'h10, 8'h00, 8'h10);
        chk("t2 read pready", {7'd0, pready[0]}, 8'h01);
        chk("t2 read prdata", prdata[0], 8'hA5);
        chk("t2 read pslverr", {7'd0, pslverr[0]}, 8'h00);
        idle(0);

        // Zero-wait back-to-back, including DEPTH-1.
        xfer(1, 1'b1, 8'h00, 8'h3C, 8'h00);
        chk("t3 w00 pready", {7'd0, pready[1]}, 8'h01);
        xfer(1, 1'b1, 8'hC7, 8'hD2, 8'hC7);
        chk("t3 wC7 pslverr", {7'd0, pslverr[1]}, 8'h00);
        xfer(1, 1'b0, 8'hC7, 8'h00, 8'h00);
        chk("t3 rC7 prdata", prdata[1], 8'hD2);
        xfer(1, 1'b0, 8'h00, 8'h00, 8'hC7);
        chk("t3 r00 prdata", prdata[1], 8'h3C);
        idle(1);

        // Out-of-range at DEPTH.
        xfer(0, 1'b1, 8'hC8, 8'h5A, 8'hC8);
        chk("t4 write pslverr", {7'd0, pslverr[0]}, 8'h01);
        xfer(0, 1'b0, 8'hC8, 8'h00, 8'hC8);
        chk("t4 read prdata", prdata[0], 8'h00);
        chk("t4 read pslverr", {7'd0, pslverr[0]}, 8'h01);
        xfer(0, 1'b0, 8'h48, 8'h00, 8'h48);
        chk("t4 alias 48", prdata[0], 8'h00);
        idle(0);

        // Address changed during ACCESS is ignored.
        xfer(0, 1'b1, 8'h20, 8'hEE, 8'h20);
        xfer(0, 1'b1, 8'h06, 8'h44, 8'h06);
        xfer(0, 1'b1, 8'h10, 8'h77, 8'h20);
        xfer(0, 1'b0, 8'h10, 8'h00, 8'h00);
        chk("t5 r10 prdata", prdata[0], 8'h77);
        xfer(0, 1'b0, 8'h20, 8'h00, 8'h00);
        chk("t5 r20 prdata", prdata[0], 8'hEE);
        idle(0);

        // Abort in first ACCESS cycle.
        xfer(0, 1'b1, 8'h30, 8'h22, 8'h30);
        idle(0);
        drop_psel(0, 8'h30, 8'h11);
        idle(0);
        chk("t6 abort proto", {7'd0, proto[0]}, 8'h01);
        xfer(0, 1'b0, 8'h30, 8'h00, 8'h30);
        chk("t6 r30 prdata", prdata[0], 8'h22);
        chk("t6 sticky proto", {7'd0, proto[0]}, 8'h01);
        idle(0);

        // penable without SETUP.
        no_setup(1, 8'h44, 8'h99);
        idle(1);
        chk("t6 nosetup proto", {7'd0, proto[1]}, 8'h01);
        xfer(1, 1'b0, 8'h44, 8'h00, 8'h44);
        chk("t6 r44 prdata", prdata[1], 8'h00);
        xfer(1, 1'b0, 8'hC7, 8'h00, 8'hC7);
        chk("t6 rC7 prdata", prdata[1], 8'hD2);
        idle(1);

        // Reset during the completing cycle of a write.
        step();
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 8'h05; pwdata[0] = 8'h33;
        for (int k = 1; k <= 3; k++) begin
            step();
            penable[0] = 1'b1;
            if (k == 3) exp_rdy[0] = 1'b1;
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t1 async pready", {7'd0, pready[0]}, 8'h00);
        chk("t1 async prdata", prdata[0], 8'h00);
        chk("t1 async proto0", {7'd0, proto[0]}, 8'h00);
        chk("t1 async proto1", {7'd0, proto[1]}, 8'h00);
        step();
        rst = 1'b0;
        psel[0] = 1'b0; penable[0] = 1'b0;
        xfer(0, 1'b0, 8'h05, 8'h00, 8'h05);
        chk("t1 r05 prdata", prdata[0], 8'h00);
        xfer(0, 1'b0, 8'h06, 8'h00, 8'h06);
        chk("t1 r06 prdata", prdata[0], 8'h00);
        idle(0);

        // penable dropped mid-ACCESS.
        drop_penable(0, 8'h40, 8'h55);
        idle(0);
        chk("pen drop proto", {7'd0, proto[0]}, 8'h01);
        xfer(0, 1'b0, 8'h40, 8'h00, 8'h40);
        chk("pen drop r40", prdata[0], 8'h00);
        idle(0);
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
